// File: rtl/multicycle_control_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_if
//   Shared memory-port handshake between the multicycle sequencer and the
//   single memory shared by instruction fetch and data access.
//
//   Signals:
//     mem_req    sequencer -> memory  access request
//     mem_we     sequencer -> memory  1 = write, 0 = read
//     iord       sequencer -> memory  address source: 0 = PC, 1 = ALU result
//     mem_ready  memory -> sequencer  current access completes this cycle
//
//   Modports:
//     master  sequencer side (drives request, receives ready)
//     slave   memory side
// ---------------------------------------------------------------------------
interface multicycle_control_if;
    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output iord, input mem_ready);
    modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Central sequencer for the 16-bit multicycle core. Steps one instruction
//   at a time through FETCH, DECODE, EXEC, MEM and WB, arbitrates the shared
//   memory port between fetch and data access, and traps into HALT or ERROR.
//
//   Parameters:
//     TIMEOUT      max cycles a request may wait for mem_ready (1..255)
//     HALT_OPCODE  opcode that stops sequencing
//
//   Ports:
//     clock, reset_n     rising-edge clock, asynchronous active-low reset
//     start              leave IDLE and begin fetching
//     opcode, zero       instruction[15:12] and ALU zero flag
//     mem                memory handshake (master modport)
//     ir_write, pc_write, pc_sel, alu_src, alu_op,
//     reg_dst, mem_to_reg, reg_write   datapath controls
//     halted, error      core is in HALT / ERROR
//     state              current state encoding, for debug
//
//   Optional feature (macro MULTICYCLE_PERF_EN):
//     adds cycle_count (cycles outside IDLE/HALT/ERROR) and instret
//     (retired instructions) performance counters.
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter int unsigned TIMEOUT     = 15,
    parameter logic [3:0]  HALT_OPCODE = 4'b1111
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [3:0]           opcode,
    input  logic                 zero,
    multicycle_control_if.master mem,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic [1:0]           pc_sel,
    output logic                 alu_src,
    output logic [1:0]           alu_op,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 reg_write,
    output logic                 halted,
    output logic                 error,
    output logic [2:0]           state
`ifdef MULTICYCLE_PERF_EN
    ,
    output logic [31:0]          cycle_count,
    output logic [31:0]          instret
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6,
        ERROR  = 3'd7
    } stateT;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b0001;
    localparam logic [3:0] OP_SW    = 4'b0010;
    localparam logic [3:0] OP_BEQ   = 4'b0011;
    localparam logic [3:0] OP_ADDI  = 4'b0100;
    localparam logic [3:0] OP_J     = 4'b0101;

    stateT       stateQ;
    stateT       nextState;
    logic [15:0] waitCount;
    logic [15:0] waitNext;
    logic        timedOut;

    // The current cycle is the TIMEOUT-th one spent waiting; a ready seen in
    // this same cycle still takes priority in the next-state logic below.
    assign waitNext = waitCount + 16'd1;
    assign timedOut = (32'(waitNext) >= TIMEOUT);
    assign state    = stateQ;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= nextState;
        end
    end

    // Wait counter restarts on every state change and only advances while
    // the memory port is being requested.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            waitCount <= '0;
        end else if (nextState != stateQ) begin
            waitCount <= '0;
        end else if (stateQ == FETCH || stateQ == MEM) begin
            waitCount <= waitNext;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        nextState    = stateQ;
        mem.mem_req  = 1'b0;
        mem.mem_we   = 1'b0;
        mem.iord     = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_sel       = 2'b00;
        alu_src      = 1'b0;
        alu_op       = 2'b00;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        reg_write    = 1'b0;
        halted       = 1'b0;
        error        = 1'b0;

        case (stateQ)
            IDLE: begin
                if (start) nextState = FETCH;
            end
            FETCH: begin
                mem.mem_req = 1'b1;
                if (mem.mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    nextState = DECODE;
                end else if (timedOut) begin
                    nextState = ERROR;
                end
            end
            DECODE: begin
                // alu_op stays at add so the branch target is precomputed.
                if (opcode == HALT_OPCODE) begin
                    nextState = HALT;
                end else begin
                    case (opcode)
                        OP_RTYPE, OP_LW, OP_SW,
                        OP_BEQ, OP_ADDI, OP_J: nextState = EXEC;
                        default:               nextState = ERROR;
                    endcase
                end
            end
            EXEC: begin
                case (opcode)
                    OP_RTYPE: begin
                        alu_op    = 2'b10;
                        nextState = WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src   = 1'b1;
                        nextState = MEM;
                    end
                    OP_ADDI: begin
                        alu_src   = 1'b1;
                        nextState = WB;
                    end
                    OP_BEQ: begin
                        alu_op    = 2'b01;
                        pc_write  = zero;
                        pc_sel    = 2'b01;
                        nextState = FETCH;
                    end
                    OP_J: begin
                        pc_write  = 1'b1;
                        pc_sel    = 2'b10;
                        nextState = FETCH;
                    end
                    default: nextState = ERROR;
                endcase
            end
            MEM: begin
                mem.mem_req = 1'b1;
                mem.iord    = 1'b1;
                mem.mem_we  = (opcode == OP_SW);
                if (mem.mem_ready) begin
                    nextState = (opcode == OP_LW) ? WB : FETCH;
                end else if (timedOut) begin
                    nextState = ERROR;
                end
            end
            WB: begin
                reg_write  = 1'b1;
                reg_dst    = (opcode == OP_RTYPE);
                mem_to_reg = (opcode == OP_LW);
                nextState  = FETCH;
            end
            HALT:    halted = 1'b1;
            ERROR:   error  = 1'b1;
            default: nextState = ERROR;
        endcase
    end

`ifdef MULTICYCLE_PERF_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cycle_count <= '0;
            instret     <= '0;
        end else begin
            if (stateQ != IDLE && stateQ != HALT && stateQ != ERROR) begin
                cycle_count <= cycle_count + 32'd1;
            end
            // An instruction retires when sequencing returns to FETCH.
            if (nextState == FETCH &&
                (stateQ == EXEC || stateQ == MEM || stateQ == WB)) begin
                instret <= instret + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//   Self-checking bench for multicycle_control. Each scenario pushes per-cycle
//   stimulus together with the expected state and control word into a
//   scoreboard queue; the entries are then popped one per cycle, applied, and
//   compared against the DUT outputs sampled 2 ns after the falling edge.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

    typedef struct packed {
        logic       memReq;
        logic       memWe;
        logic       iord;
        logic       irWrite;
        logic       pcWrite;
        logic [1:0] pcSel;
        logic       aluSrc;
        logic [1:0] aluOp;
        logic       regDst;
        logic       memToReg;
        logic       regWrite;
        logic       halted;
        logic       error;
    } ctrlT;

    typedef struct {
        logic       start;
        logic [3:0] op;
        logic       zero;
        logic       ready;
        logic [2:0] st;
        ctrlT       ctrl;
    } entryT;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3;
    localparam logic [2:0] S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6, S_ERROR = 3'd7;

    localparam ctrlT C_NONE       = '0;
    localparam ctrlT C_FETCH_WAIT = '{memReq: 1'b1, default: '0};
    localparam ctrlT C_FETCH_DONE = '{memReq: 1'b1, irWrite: 1'b1, pcWrite: 1'b1, default: '0};
    localparam ctrlT C_EXEC_R     = '{aluOp: 2'b10, default: '0};
    localparam ctrlT C_EXEC_IMM   = '{aluSrc: 1'b1, default: '0};
    localparam ctrlT C_EXEC_BEQ_T = '{aluOp: 2'b01, pcWrite: 1'b1, pcSel: 2'b01, default: '0};
    localparam ctrlT C_EXEC_BEQ_N = '{aluOp: 2'b01, pcSel: 2'b01, default: '0};
    localparam ctrlT C_EXEC_J     = '{pcWrite: 1'b1, pcSel: 2'b10, default: '0};
    localparam ctrlT C_MEM_RD     = '{memReq: 1'b1, iord: 1'b1, default: '0};
    localparam ctrlT C_MEM_WR     = '{memReq: 1'b1, iord: 1'b1, memWe: 1'b1, default: '0};
    localparam ctrlT C_WB_R       = '{regWrite: 1'b1, regDst: 1'b1, default: '0};
    localparam ctrlT C_WB_LW      = '{regWrite: 1'b1, memToReg: 1'b1, default: '0};
    localparam ctrlT C_WB_ADDI    = '{regWrite: 1'b1, default: '0};
    localparam ctrlT C_HALT       = '{halted: 1'b1, default: '0};
    localparam ctrlT C_ERROR      = '{error: 1'b1, default: '0};

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic [3:0] opcode;
    logic       zero;
    logic       ir_write, pc_write, alu_src, reg_dst, mem_to_reg, reg_write;
    logic       halted, error;
    logic [1:0] pc_sel, alu_op;
    logic [2:0] state;
`ifdef MULTICYCLE_PERF_EN
    logic [31:0] cycle_count, instret;
`endif

    multicycle_control_if memBus ();

    multicycle_control dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .opcode     (opcode),
        .zero       (zero),
        .mem        (memBus),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_sel     (pc_sel),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .halted     (halted),
        .error      (error),
        .state      (state)
`ifdef MULTICYCLE_PERF_EN
        ,
        .cycle_count(cycle_count),
        .instret    (instret)
`endif
    );

    always #5 clock = ~clock;

    int    checks = 0;
    int    errors = 0;
    entryT sb[$];

    function automatic ctrlT observed();
        return {memBus.mem_req, memBus.mem_we, memBus.iord, ir_write, pc_write, pc_sel,
                alu_src, alu_op, reg_dst, mem_to_reg, reg_write, halted, error};
    endfunction

    task automatic push(input logic s, input logic [3:0] op, input logic z, input logic r,
                        input logic [2:0] st, input ctrlT c);
        entryT e;
        e.start = s; e.op = op; e.zero = z; e.ready = r; e.st = st; e.ctrl = c;
        sb.push_back(e);
    endtask

    task automatic doReset();
        reset_n = 1'b0; start = 1'b0; opcode = 4'd0; zero = 1'b0; memBus.mem_ready = 1'b0;
        sb.delete();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        entryT e;
        doReset();
        push(1'b0, 4'd0, 1'b0, 1'b1, S_IDLE, C_NONE);
        push(1'b0, 4'd0, 1'b0, 1'b1, S_IDLE, C_NONE);
        push(1'b1, 4'd0, 1'b0, 1'b1, S_IDLE, C_NONE);
        push(1'b0, 4'd0, 1'b0, 1'b0, S_FETCH, C_FETCH_WAIT);
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front();
            @(negedge clock);
            start = e.start; opcode = e.op; zero = e.zero; memBus.mem_ready = e.ready;
            #2;
            checks++;
            if (state !== e.st || observed() !== e.ctrl) begin
                errors++;
                $display("FAIL reset step %0d: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                         i, state, observed(), e.st, e.ctrl);
            end
        end
        // Asynchronous reset with start held high must keep the core idle.
        reset_n = 1'b0; start = 1'b1;
        #1;
        checks++;
        if (state !== S_IDLE || observed() !== C_NONE) begin
            errors++;
            $display("FAIL reset_async: got state=%0d ctrl=%b, expected state=0 ctrl=0",
                     state, observed());
        end
        @(negedge clock);
        @(negedge clock);
        #2;
        checks++;
        if (state !== S_IDLE) begin
            errors++;
            $display("FAIL reset_hold: got state=%0d, expected 0", state);
        end
    endtask

    task automatic test_rtype();
        entryT e;
        doReset();
        push(1'b1, 4'b0000, 1'b0, 1'b1, S_IDLE, C_NONE);
        for (int n = 0; n < 2; n++) begin
            push(1'b1, 4'b0000, 1'b0, 1'b1, S_FETCH, C_FETCH_DONE);
            push(1'b1, 4'b0000, 1'b0, 1'b1, S_DECODE, C_NONE);
            push(1'b1, 4'b0000, 1'b0, 1'b1, S_EXEC, C_EXEC_R);
            push(1'b1, 4'b0000, 1'b0, 1'b1, S_WB, C_WB_R);
        end
        push(1'b0, 4'b0000, 1'b0, 1'b0, S_FETCH, C_FETCH_WAIT);
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front();
            @(negedge clock);
            start = e.start; opcode = e.op; zero = e.zero; memBus.mem_ready = e.ready;
            #2;
            checks++;
            if (state !== e.st || observed() !== e.ctrl) begin
                errors++;
                $display("FAIL rtype step %0d: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                         i, state, observed(), e.st, e.ctrl);
            end
        end
    endtask

    task automatic test_lw_wait();
        entryT e;
        doReset();
        push(1'b1, 4'b0001, 1'b0, 1'b1, S_IDLE, C_NONE);
        push(1'b0, 4'b0001, 1'b0, 1'b1, S_FETCH, C_FETCH_DONE);
        push(1'b0, 4'b0001, 1'b0, 1'b1, S_DECODE, C_NONE);
        push(1'b0, 4'b0001, 1'b0, 1'b1, S_EXEC, C_EXEC_IMM);
        for (int n = 0; n < 3; n++) push(1'b0, 4'b0001, 1'b0, 1'b0, S_MEM, C_MEM_RD);
        push(1'b0, 4'b0001, 1'b0, 1'b1, S_MEM, C_MEM_RD);
        push(1'b0, 4'b0001, 1'b0, 1'b1, S_WB, C_WB_LW);
        push(1'b0, 4'b0001, 1'b0, 1'b1, S_FETCH, C_FETCH_DONE);
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front();
            @(negedge clock);
            start = e.start; opcode = e.op; zero = e.zero; memBus.mem_ready = e.ready;
            #2;
            checks++;
            if (state !== e.st || observed() !== e.ctrl) begin
                errors++;
                $display("FAIL lw_wait step %0d: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                         i, state, observed(), e.st, e.ctrl);
            end
        end
    endtask

    task automatic test_beq();
        entryT e;
        doReset();
        push(1'b1, 4'b0011, 1'b1, 1'b1, S_IDLE, C_NONE);
        push(1'b0, 4'b0011, 1'b1, 1'b1, S_FETCH, C_FETCH_DONE);
        push(1'b0, 4'b0011, 1'b1, 1'b1, S_DECODE, C_NONE);
        push(1'b0, 4'b0011, 1'b1, 1'b1, S_EXEC, C_EXEC_BEQ_T);
        push(1'b0, 4'b0011, 1'b0, 1'b1, S_FETCH, C_FETCH_DONE);
        push(1'b0, 4'b0011, 1'b0, 1'b1, S_DECODE, C_NONE);
        push(1'b0, 4'b0011, 1'b0, 1'b1, S_EXEC, C_EXEC_BEQ_N);
        push(1'b0, 4'b0011, 1'b0, 1'b0, S_FETCH, C_FETCH_WAIT);
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front();
            @(negedge clock);
            start = e.start; opcode = e.op; zero = e.zero; memBus.mem_ready = e.ready;
            #2;
            checks++;
            if (state !== e.st || observed() !== e.ctrl) begin
                errors++;
                $display("FAIL beq step %0d: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                         i, state, observed(), e.st, e.ctrl);
            end
        end
    endtask

    // ADDI, SW and J issued back to back with zero memory wait.
    task automatic test_back_to_back();
        entryT e;
        doReset();
        push(1'b1, 4'b0100, 1'b0, 1'b1, S_IDLE, C_NONE);
        push(1'b0, 4'b0100, 1'b0, 1'b1, S_FETCH, C_FETCH_DONE);
        push(1'b0, 4'b0100, 1'b0, 1'b1, S_DECODE, C_NONE);
        push(1'b0, 4'b0100, 1'b0, 1'b1, S_EXEC, C_EXEC_IMM);
        push(1'b0, 4'b0100, 1'b0, 1'b1, S_WB, C_WB_ADDI);
        push(1'b0, 4'b0010, 1'b0, 1'b1, S_FETCH, C_FETCH_DONE);
        push(1'b0, 4'b0010, 1'b0, 1'b1, S_DECODE, C_NONE);
        push(1'b0, 4'b0010, 1'b0, 1'b1, S_EXEC, C_EXEC_IMM);
        push(1'b0, 4'b0010, 1'b0, 1'b1, S_MEM, C_MEM_WR);
        push(1'b0, 4'b0101, 1'b0, 1'b1, S_FETCH, C_FETCH_DONE);
        push(1'b0, 4'b0101, 1'b0, 1'b1, S_DECODE, C_NONE);
        push(1'b0, 4'b0101, 1'b0, 1'b1, S_EXEC, C_EXEC_J);
        push(1'b0, 4'b0000, 1'b0, 1'b1, S_FETCH, C_FETCH_DONE);
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front();
            @(negedge clock);
            start = e.start; opcode = e.op; zero = e.zero; memBus.mem_ready = e.ready;
            #2;
            checks++;
            if (state !== e.st || observed() !== e.ctrl) begin
                errors++;
                $display("FAIL b2b step %0d: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                         i, state, observed(), e.st, e.ctrl);
            end
        end
`ifdef MULTICYCLE_PERF_EN
        // 4 + 4 + 3 active cycles completed, three instructions retired.
        checks++;
        if (cycle_count !== 32'd11 || instret !== 32'd3) begin
            errors++;
            $display("FAIL perf_count: got cycle_count=%0d instret=%0d, expected 11 and 3",
                     cycle_count, instret);
        end
`endif
    endtask

    // ready=0 for TIMEOUT cycles traps; ready on the last allowed cycle wins.
    task automatic test_timeout();
        entryT e;
        doReset();
        push(1'b1, 4'b0000, 1'b0, 1'b0, S_IDLE, C_NONE);
        for (int n = 0; n < 15; n++) push(1'b0, 4'b0000, 1'b0, 1'b0, S_FETCH, C_FETCH_WAIT);
        push(1'b0, 4'b0000, 1'b0, 1'b1, S_ERROR, C_ERROR);
        push(1'b1, 4'b0000, 1'b0, 1'b1, S_ERROR, C_ERROR);
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front();
            @(negedge clock);
            start = e.start; opcode = e.op; zero = e.zero; memBus.mem_ready = e.ready;
            #2;
            checks++;
            if (state !== e.st || observed() !== e.ctrl) begin
                errors++;
                $display("FAIL timeout step %0d: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                         i, state, observed(), e.st, e.ctrl);
            end
        end
        doReset();
        push(1'b1, 4'b0000, 1'b0, 1'b0, S_IDLE, C_NONE);
        for (int n = 0; n < 14; n++) push(1'b0, 4'b0000, 1'b0, 1'b0, S_FETCH, C_FETCH_WAIT);
        push(1'b0, 4'b0000, 1'b0, 1'b1, S_FETCH, C_FETCH_DONE);
        push(1'b0, 4'b0000, 1'b0, 1'b1, S_DECODE, C_NONE);
        push(1'b0, 4'b0000, 1'b0, 1'b1, S_EXEC, C_EXEC_R);
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front();
            @(negedge clock);
            start = e.start; opcode = e.op; zero = e.zero; memBus.mem_ready = e.ready;
            #2;
            checks++;
            if (state !== e.st || observed() !== e.ctrl) begin
                errors++;
                $display("FAIL timeout_edge step %0d: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                         i, state, observed(), e.st, e.ctrl);
            end
        end
    endtask

    task automatic test_illegal_and_halt();
        entryT e;
        doReset();
        push(1'b1, 4'b1010, 1'b0, 1'b1, S_IDLE, C_NONE);
        push(1'b0, 4'b1010, 1'b0, 1'b1, S_FETCH, C_FETCH_DONE);
        push(1'b0, 4'b1010, 1'b0, 1'b1, S_DECODE, C_NONE);
        push(1'b1, 4'b1010, 1'b0, 1'b1, S_ERROR, C_ERROR);
        push(1'b0, 4'b0000, 1'b0, 1'b1, S_ERROR, C_ERROR);
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front();
            @(negedge clock);
            start = e.start; opcode = e.op; zero = e.zero; memBus.mem_ready = e.ready;
            #2;
            checks++;
            if (state !== e.st || observed() !== e.ctrl) begin
                errors++;
                $display("FAIL illegal step %0d: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                         i, state, observed(), e.st, e.ctrl);
            end
        end
        doReset();
        push(1'b1, 4'b1111, 1'b0, 1'b1, S_IDLE, C_NONE);
        push(1'b0, 4'b1111, 1'b0, 1'b1, S_FETCH, C_FETCH_DONE);
        push(1'b0, 4'b1111, 1'b0, 1'b1, S_DECODE, C_NONE);
        push(1'b1, 4'b1111, 1'b0, 1'b1, S_HALT, C_HALT);
        push(1'b0, 4'b0000, 1'b0, 1'b1, S_HALT, C_HALT);
        push(1'b1, 4'b0000, 1'b0, 1'b1, S_HALT, C_HALT);
        push(1'b0, 4'b0000, 1'b0, 1'b1, S_HALT, C_HALT);
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front();
            @(negedge clock);
            start = e.start; opcode = e.op; zero = e.zero; memBus.mem_ready = e.ready;
            #2;
            checks++;
            if (state !== e.st || observed() !== e.ctrl) begin
                errors++;
                $display("FAIL halt step %0d: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                         i, state, observed(), e.st, e.ctrl);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        entryT e;
        doReset();
        push(1'b1, 4'b0010, 1'b0, 1'b1, S_IDLE, C_NONE);
        push(1'b0, 4'b0010, 1'b0, 1'b1, S_FETCH, C_FETCH_DONE);
        push(1'b0, 4'b0010, 1'b0, 1'b1, S_DECODE, C_NONE);
        push(1'b0, 4'b0010, 1'b0, 1'b0, S_EXEC, C_EXEC_IMM);
        push(1'b0, 4'b0010, 1'b0, 1'b0, S_MEM, C_MEM_WR);
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front();
            @(negedge clock);
            start = e.start; opcode = e.op; zero = e.zero; memBus.mem_ready = e.ready;
            #2;
            checks++;
            if (state !== e.st || observed() !== e.ctrl) begin
                errors++;
                $display("FAIL mid_write step %0d: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                         i, state, observed(), e.st, e.ctrl);
            end
        end
        // Reset lands in the middle of the clock cycle, away from any edge.
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (state !== S_IDLE || observed() !== C_NONE) begin
            errors++;
            $display("FAIL mid_write_reset: got state=%0d ctrl=%b, expected state=0 ctrl=0",
                     state, observed());
        end
`ifdef MULTICYCLE_PERF_EN
        checks++;
        if (cycle_count !== 32'd0 || instret !== 32'd0) begin
            errors++;
            $display("FAIL perf_reset: got cycle_count=%0d instret=%0d, expected 0 and 0",
                     cycle_count, instret);
        end
`endif
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_beq();
        test_back_to_back();
        test_timeout();
        test_illegal_and_halt();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
